// File: rtl/rob_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, records CDB completions, retires in order.
// Optional define ROB_CDB_BYPASS_EN forwards a same-cycle CDB result onto the operand read ports.
module rob_entry (
    input  logic        clock,
    input  logic        reset,
    input  logic        alloc,
    input  logic        dp_has_dest,
    input  logic [4:0]  dp_dest_reg_idx,
    input  logic        set_complete,
    input  logic [31:0] value_in,
    input  logic        clear,
    output logic        valid,
    output logic        complete,
    output logic        has_dest,
    output logic [4:0]  dest_reg_idx,
    output logic [31:0] value
);
    // Clear (retire) wins over a late CDB rewrite of the head entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid        <= 1'b0;
            complete     <= 1'b0;
            has_dest     <= 1'b0;
            dest_reg_idx <= '0;
            value        <= '0;
        end else if (clear) begin
            valid    <= 1'b0;
            complete <= 1'b0;
        end else if (alloc) begin
            valid        <= 1'b1;
            complete     <= 1'b0;
            has_dest     <= dp_has_dest;
            dest_reg_idx <= dp_dest_reg_idx;
        end else if (set_complete) begin
            complete <= 1'b1;
            value    <= value_in;
        end
    end
endmodule

module rob_buffer #(
    parameter int ROB_SZ = 8,
    parameter int TAG_W  = $clog2(ROB_SZ + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dispatch_valid,
    input  logic              dp_has_dest,
    input  logic [4:0]        dp_dest_reg_idx,
    output logic              rob_full,
    output logic [TAG_W-1:0]  rob_new_tail_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [31:0]       cdb_value,
    output logic              retire_valid,
    output logic [TAG_W-1:0]  retire_tag,
    output logic              retire_has_dest,
    output logic [4:0]        retire_dest_reg_idx,
    output logic [31:0]       retire_value,
    input  logic [TAG_W-1:0]  rd_tag_a,
    input  logic [TAG_W-1:0]  rd_tag_b,
    output logic              rd_ready_a,
    output logic              rd_ready_b,
    output logic [31:0]       rd_value_a,
    output logic [31:0]       rd_value_b
);
    localparam int PTR_W = $clog2(ROB_SZ);
    localparam int CNT_W = $clog2(ROB_SZ + 1);

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic [ROB_SZ-1:0]       ent_valid, ent_complete, ent_has_dest;
    logic [ROB_SZ-1:0][4:0]  ent_dest;
    logic [ROB_SZ-1:0][31:0] ent_value;

    function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
        return (int'(t) >= 1) && (int'(t) <= ROB_SZ);
    endfunction

    function automatic logic [PTR_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
        return PTR_W'(t - TAG_W'(1));
    endfunction

    logic             dispatch_ok, retire_ok, cdb_hit;
    logic [PTR_W-1:0] cdb_idx;

    // Outputs read as idle while reset is held, even with stale entries still present.
    assign rob_full         = !reset && (count == CNT_W'(ROB_SZ));
    assign rob_new_tail_tag = reset ? TAG_W'(1) : TAG_W'(tail) + TAG_W'(1);
    assign dispatch_ok      = dispatch_valid && !rob_full;
    assign cdb_idx          = tag_idx(cdb_tag);
    assign cdb_hit          = cdb_valid && tag_in_range(cdb_tag) && ent_valid[cdb_idx];
    assign retire_ok        = !reset && (count != '0) && ent_valid[head] && ent_complete[head];

    for (genvar i = 0; i < ROB_SZ; i++) begin : g_ent
        rob_entry u_ent (
            .clock           (clock),
            .reset           (reset),
            .alloc           (dispatch_ok && (tail == PTR_W'(i))),
            .dp_has_dest     (dp_has_dest),
            .dp_dest_reg_idx (dp_dest_reg_idx),
            .set_complete    (cdb_hit && (cdb_idx == PTR_W'(i))),
            .value_in        (cdb_value),
            .clear           (retire_ok && (head == PTR_W'(i))),
            .valid           (ent_valid[i]),
            .complete        (ent_complete[i]),
            .has_dest        (ent_has_dest[i]),
            .dest_reg_idx    (ent_dest[i]),
            .value           (ent_value[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (dispatch_ok) tail <= tail + PTR_W'(1);
            if (retire_ok)   head <= head + PTR_W'(1);
            case ({dispatch_ok, retire_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        retire_valid        = 1'b0;
        retire_tag          = '0;
        retire_has_dest     = 1'b0;
        retire_dest_reg_idx = '0;
        retire_value        = '0;
        if (retire_ok) begin
            retire_valid        = 1'b1;
            retire_tag          = TAG_W'(head) + TAG_W'(1);
            retire_has_dest     = ent_has_dest[head];
            retire_dest_reg_idx = ent_dest[head];
            retire_value        = ent_value[head];
        end
    end

    logic [1:0][TAG_W-1:0] rd_tag;
    logic [1:0]            rd_ready;
    logic [1:0][31:0]      rd_value;

    assign rd_tag = {rd_tag_b, rd_tag_a};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [PTR_W-1:0] idx;
        logic             hit, byp;
        assign idx = tag_idx(rd_tag[p]);
        assign hit = tag_in_range(rd_tag[p]) && ent_valid[idx] && ent_complete[idx];
`ifdef ROB_CDB_BYPASS_EN
        assign byp = cdb_hit && (rd_tag[p] == cdb_tag);
`else
        assign byp = 1'b0;
`endif
        assign rd_ready[p] = !reset && (byp || hit);
        assign rd_value[p] = reset ? '0 : byp ? cdb_value : hit ? ent_value[idx] : '0;
    end

    assign rd_ready_a = rd_ready[0];
    assign rd_ready_b = rd_ready[1];
    assign rd_value_a = rd_value[0];
    assign rd_value_b = rd_value[1];
endmodule

// File: tb/tb_rob_buffer.sv
// Directed + random bench for rob_buffer against an in-order queue reference model.
module tb_rob_buffer;
    localparam int ROB_SZ = 8;
    localparam int TAG_W  = $clog2(ROB_SZ + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic              dispatch_valid, dp_has_dest;
    logic [4:0]        dp_dest_reg_idx;
    logic              rob_full;
    logic [TAG_W-1:0]  rob_new_tail_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_value;
    logic              retire_valid, retire_has_dest;
    logic [TAG_W-1:0]  retire_tag;
    logic [4:0]        retire_dest_reg_idx;
    logic [31:0]       retire_value;
    logic [TAG_W-1:0]  rd_tag_a, rd_tag_b;
    logic              rd_ready_a, rd_ready_b;
    logic [31:0]       rd_value_a, rd_value_b;

    rob_buffer #(.ROB_SZ(ROB_SZ), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dp_has_dest(dp_has_dest), .dp_dest_reg_idx(dp_dest_reg_idx),
        .rob_full(rob_full), .rob_new_tail_tag(rob_new_tail_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_has_dest(retire_has_dest),
        .retire_dest_reg_idx(retire_dest_reg_idx), .retire_value(retire_value),
        .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
        .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
        .rd_value_a(rd_value_a), .rd_value_b(rd_value_b)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: in-flight tags in program order plus per-tag records.
    int          q[$];
    int          next_tag = 1;
    bit          done[16];
    bit          mhd[16];
    logic [4:0]  mdest[16];
    logic [31:0] mval[16];

    function automatic bit live(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit bypass_hit(input int t);
`ifdef ROB_CDB_BYPASS_EN
        return cdb_valid && (int'(cdb_tag) != 0) && live(int'(cdb_tag)) && (t == int'(cdb_tag));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_ready(input int t);
        return bypass_hit(t) || (live(t) && done[t]);
    endfunction

    function automatic logic [31:0] exp_value(input int t);
        if (bypass_hit(t)) return cdb_value;
        if (live(t) && done[t]) return mval[t];
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all();
        bit rv;
        int h;
        if (reset) begin
            chk("rst_full", 32'(rob_full), 32'h0);
            chk("rst_tail_tag", 32'(rob_new_tail_tag), 32'h1);
            chk("rst_retire_valid", 32'(retire_valid), 32'h0);
            chk("rst_rd_ready_a", 32'(rd_ready_a), 32'h0);
            chk("rst_rd_ready_b", 32'(rd_ready_b), 32'h0);
            return;
        end
        rv = (q.size() > 0) && done[q[0]];
        h  = rv ? q[0] : 0;
        chk("rob_full", 32'(rob_full), 32'(q.size() == ROB_SZ));
        chk("new_tail_tag", 32'(rob_new_tail_tag), 32'(next_tag));
        chk("retire_valid", 32'(retire_valid), 32'(rv));
        chk("retire_tag", 32'(retire_tag), 32'(h));
        chk("retire_has_dest", 32'(retire_has_dest), rv ? 32'(mhd[h]) : 32'h0);
        chk("retire_dest", 32'(retire_dest_reg_idx), rv ? 32'(mdest[h]) : 32'h0);
        chk("retire_value", retire_value, rv ? mval[h] : 32'h0);
        chk("rd_ready_a", 32'(rd_ready_a), 32'(exp_ready(int'(rd_tag_a))));
        chk("rd_value_a", rd_value_a, exp_value(int'(rd_tag_a)));
        chk("rd_ready_b", 32'(rd_ready_b), 32'(exp_ready(int'(rd_tag_b))));
        chk("rd_value_b", rd_value_b, exp_value(int'(rd_tag_b)));
    endtask

    task automatic model_edge();
        bit rv, disp, cdbh;
        int t;
        if (reset) begin
            q.delete();
            next_tag = 1;
            foreach (done[i]) done[i] = 1'b0;
            return;
        end
        rv   = (q.size() > 0) && done[q[0]];
        disp = dispatch_valid && (q.size() < ROB_SZ);
        cdbh = cdb_valid && live(int'(cdb_tag));
        if (cdbh) begin
            done[int'(cdb_tag)] = 1'b1;
            mval[int'(cdb_tag)] = cdb_value;
        end
        if (rv) void'(q.pop_front());
        if (disp) begin
            t = next_tag;
            done[t]  = 1'b0;
            mhd[t]   = dp_has_dest;
            mdest[t] = dp_dest_reg_idx;
            q.push_back(t);
            next_tag = next_tag % ROB_SZ + 1;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_cdb(input bit v, input int t, input logic [31:0] val);
        cdb_valid = v;
        cdb_tag   = TAG_W'(t);
        cdb_value = val;
    endtask

    task automatic rand_dispatch(input bit v);
        dispatch_valid  = v;
        dp_has_dest     = 1'($urandom);
        dp_dest_reg_idx = 5'($urandom);
    endtask

    function automatic int pick_tag();
        if (q.size() > 0 && ($urandom % 4) != 0) return q[$urandom % q.size()];
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        reset = 1'b1;
        rand_dispatch(1'b0);
        set_cdb(1'b0, 0, 32'h0);
        rd_tag_a = '0;
        rd_tag_b = '0;
        cycle();
        cycle();
        reset = 1'b0;

        // Idle after reset
        rd_tag_a = TAG_W'(1);
        cycle();

        // Fill: tags 1..8, then an ignored dispatch while full
        for (int i = 0; i < ROB_SZ; i++) begin
            rand_dispatch(1'b1);
            cycle();
        end
        rand_dispatch(1'b1);
        cycle();
        chk("tail_tag_wrapped_full", 32'(rob_new_tail_tag), 32'h1);
        chk("full_after_8", 32'(rob_full), 32'h1);
        rand_dispatch(1'b0);

        // Out-of-order completion: 3 first, then 1 and 2
        set_cdb(1'b1, 3, 32'h33);
        cycle();
        set_cdb(1'b0, 0, 32'h0);
        cycle();
        set_cdb(1'b1, 1, 32'h11);
        cycle();
        set_cdb(1'b1, 2, 32'h22);
        rd_tag_b = TAG_W'(3);
        cycle();
        set_cdb(1'b0, 0, 32'h0);
        cycle();
        cycle();

        // Wrap-around: tags 1..3 reused
        for (int i = 0; i < 3; i++) begin
            rand_dispatch(1'b1);
            cycle();
        end
        rand_dispatch(1'b0);
        chk("full_after_wrap", 32'(rob_full), 32'h1);
        set_cdb(1'b1, 4, 32'h44);
        cycle();
        // Full: dispatch ignored despite retire of tag 4; tag 5 completes with read-port lookup
        rand_dispatch(1'b1);
        set_cdb(1'b1, 5, 32'hABCD);
        rd_tag_a = TAG_W'(5);
        cycle();
        // Dispatch + retire in the same cycle
        set_cdb(1'b0, 0, 32'h0);
        cycle();
        rand_dispatch(1'b0);
        chk("full_after_swap", 32'(rob_full), 32'h0);
        cycle();

        // Reset with entries in flight, then a stale CDB
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_dispatch(1'b1);
            cycle();
        end
        rand_dispatch(1'b0);
        set_cdb(1'b1, 1, 32'h1111);
        cycle();
        reset = 1'b1;
        set_cdb(1'b1, 2, 32'h2222);
        cycle();
        reset = 1'b0;
        set_cdb(1'b1, 2, 32'h2222);
        rd_tag_a = TAG_W'(2);
        rd_tag_b = TAG_W'(1);
        cycle();
        set_cdb(1'b0, 0, 32'h0);
        cycle();
        chk("stale_cdb_no_ready", 32'(rd_ready_a), 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset = (($urandom % 64) == 0);
            rand_dispatch(($urandom % 3) != 0);
            set_cdb(($urandom % 3) != 0, pick_tag(), $urandom);
            rd_tag_a = TAG_W'(pick_tag());
            rd_tag_b = TAG_W'(pick_tag());
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
- Circular reorder buffer that sits directly upstream of the register map table.
- Allocates a ROB tag to each dispatched instruction and records CDB completions.
- Retires instructions in program order and supplies the retire/new-tail information the map table uses to tag and clear entries.
- Exposes two tag-indexed read ports so the reservation stations can fetch operands whose map entry is marked ready-in-ROB (t_plus).

Parameters:
- ROB_SZ, 8, number of entries (power of two, ≥2).
- TAG_W, $clog2(ROB_SZ+1), width of a ROB tag. Tag 0 means "no tag"; valid tags are 1..ROB_SZ, and entry index = tag-1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dispatch_valid  in  1  dispatch request this cycle
- dp_has_dest  in  1  dispatched instruction writes a register
- dp_dest_reg_idx  in  5  architectural destination register
- rob_full  out  1  no free entry
- rob_new_tail_tag  out  TAG_W  tag given to the instruction dispatched this cycle
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  completing tag
- cdb_value  in  32  result value
- retire_valid  out  1  head entry retires this cycle
- retire_tag  out  TAG_W  tag of the retiring entry
- retire_has_dest  out  1  retiring entry writes a register
- retire_dest_reg_idx  out  5  destination of the retiring entry
- retire_value  out  32  result value of the retiring entry
- rd_tag_a, rd_tag_b  in  TAG_W  operand lookup tags
- rd_ready_a, rd_ready_b  out  1  looked-up entry is valid and complete
- rd_value_a, rd_value_b  out  32  looked-up value; 0 when not ready

Behaviour:
- State:
  - head and tail pointers, each log2(ROB_SZ) bits, wrapping modulo ROB_SZ.
  - count, 0..ROB_SZ.
  - Per entry: valid, complete, has_dest, dest_reg_idx, value.
- Reset: head=tail=count=0; all entries have valid=0 and complete=0. Output values in reset: rob_full=0, rob_new_tail_tag=1, retire_valid=0, rd_ready_*=0. A reset mid-operation discards every in-flight entry; no retire is issued in the reset cycle or the cycle after it.
- Combinational outputs:
  - rob_full = (count==ROB_SZ).
  - rob_new_tail_tag = tail+1, valid whether or not dispatch occurs.
- Dispatch is accepted when dispatch_valid && !rob_full. At the edge:
  - Entry[tail] gets valid=1, complete=0, has_dest and dest_reg_idx.
  - tail advances by 1.
  - A dispatch request while full is ignored: no state change.
  - A same-cycle retire does not free space for a same-cycle dispatch.
- CDB:
  - If cdb_valid, cdb_tag != 0 and entry[cdb_tag-1].valid, then at the edge that entry gets complete=1 and value=cdb_value.
  - A CDB to tag 0 or to an invalid entry is ignored.
- Retire:
  - retire_valid = count>0 && entry[head].valid && entry[head].complete. This is combinational, and the map table sees it in the same cycle.
  - retire_tag, retire_has_dest, retire_dest_reg_idx and retire_value come from entry[head]. They are 0 when retire_valid=0.
  - At the edge: entry[head].valid=0, complete=0, head advances.
  - At most one retire per cycle.
  - An entry completed by the CDB in cycle N retires in cycle N+1 at the earliest.
- Count update:
  - Dispatch only: +1.
  - Retire only: -1.
  - Both in the same cycle: unchanged.
- Simultaneous events: dispatch, CDB and retire all in one cycle is legal; each updates a distinct entry.
- Read ports:
  - Combinational.
  - rd_ready_x = tag!=0 && entry[tag-1].valid && entry[tag-1].complete.
  - rd_value_x = entry value when ready, else 0.
- Wrap-around: after tag ROB_SZ, the next allocation is tag 1. Tags are reused only after retire.

Optional Feature:
- Macro: ROB_CDB_BYPASS_EN.
- Defined: a read port whose tag matches a same-cycle valid CDB broadcast (cdb_tag!=0, entry valid) returns rd_ready=1 and rd_value=cdb_value in that cycle.
- Undefined: the completion is visible on the read ports only from the next cycle.
- Retire timing is the same in both cases.

Test Plan:
- Reset, then idle: rob_full=0, rob_new_tail_tag=1, retire_valid=0, rd_ready_a=0 for rd_tag_a=1.
- Dispatch 8 consecutive cycles (ROB_SZ=8) -> tags 1..8 allocated in order, rob_full=1 after the 8th. A 9th dispatch is ignored and rob_new_tail_tag stays 1.
- Out-of-order completion:
  - From the full state, CDB tag 3 value 0x33 -> retire_valid stays 0.
  - Then CDB tag 1 (0x11) and tag 2 (0x22) -> retires 1, 2, 3 on three consecutive cycles, with retire_value 0x11, 0x22, 0x33.
  - retire_dest_reg_idx matches the index given at dispatch.
- Wrap-around: after retiring tags 1–3, dispatch 3 more -> tags 1, 2, 3 reused; rob_full=1. Same-cycle dispatch+retire keeps count constant.
- Read port: CDB tag 5 value 0xABCD with rd_tag_a=5 in the same cycle -> rd_ready_a=1 that cycle with ROB_CDB_BYPASS_EN, else only the next cycle. Afterwards rd_value_a=0xABCD in both builds.
- Reset asserted with 4 entries in flight -> next cycle count=0, rob_full=0, rob_new_tail_tag=1, retire_valid=0; a CDB for a stale tag has no effect.
